register_writeback_queue: RTL and testbench
===========================================

# register_writeback_queue

Initiator side of the register-file write port. Buffers writeback requests from the execute/memory stages in a small in-order FIFO and drives `write_register` / `write_data` / `write_activate` into the register file. Each entry is retired only when the register file returns `write_done`. Two lookup ports let the read stage see values that are still queued and not yet written.

## Interface

Parameters:
- `WIDTH`, 32, data width of one register.
- `DEPTH`, 4, number of queue entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `flush`  in  1  synchronous clear of all queued entries.
- `wb_valid`  in  1  producer offers a writeback this cycle.
- `wb_ready`  out  1  queue can accept; `wb_ready = (count < DEPTH) && !flush`.
- `wb_register`  in  5  destination register index.
- `wb_data`  in  WIDTH  value to write.
- `write_register`  out  5  register-file write index (head entry).
- `write_data`  out  WIDTH  register-file write data (head entry).
- `write_activate`  out  1  head entry is valid and is being presented.
- `write_done`  in  1  register file accepts the presented write this cycle.
- `lookup_register_1`, `lookup_register_2`  in  5  read-stage register indices.
- `lookup_hit_1`, `lookup_hit_2`  out  1  a queued entry targets that index.
- `lookup_data_1`, `lookup_data_2`  out  WIDTH  data of the youngest matching entry.
- `count`  out  $clog2(DEPTH)+1  number of queued entries.
- `empty`  out  1  `count == 0`.

## Operation

- Storage is a circular buffer with a head pointer, a tail pointer and a count register; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Enqueue.** Occurs on an edge where `wb_valid && wb_ready`.
  - If `wb_register != 0`: write the entry at tail, tail+1, count+1.
  - If `wb_register == 0`: the request is accepted (handshake completes) but discarded. No entry is created and count is unchanged.
- **Presentation FSM, two states.**
  - IDLE: count == 0, `write_activate` = 0.
  - PRESENT: count > 0, `write_activate` = 1, and `write_register` / `write_data` show the head entry.
- **Retire.** Occurs on an edge where `write_activate && write_done`: head+1, count−1. `write_done` while `write_activate` = 0 is ignored.
- **Simultaneous enqueue and retire.** Count is unchanged; both pointers advance.
- **Full.** When count == DEPTH, `wb_ready` = 0. A retire in the same cycle does not raise `wb_ready` combinationally; space becomes visible the next cycle.
- **Flush.**
  - On an edge with `flush` = 1: head = tail = count = 0, and any concurrent retire or enqueue is dropped.
  - `wb_ready` is 0 while `flush` is high.
  - The head write in flight at that edge is abandoned, even if `write_done` was high.
- **Idle outputs.** When `write_activate` = 0, `write_register` = 0 and `write_data` = 0. No stale data is ever presented.
- **Lookup (combinational).**
  - Scan valid entries youngest to oldest; the first entry whose register equals the lookup index wins.
  - Index 0 never hits.
  - On a miss, `lookup_hit` = 0 and `lookup_data` = 0.
  - Lookup does not see a request being enqueued in the current cycle; it sees it from the next cycle on.
- Ordering is strictly FIFO. Multiple entries to the same register are all written, oldest first.

## Timing

- **Reset (rst = 0, asynchronous).** All pointers and count = 0, `write_activate` = 0, `write_register` = 0, `write_data` = 0, `wb_ready` = 1 (if flush = 0), `empty` = 1, lookup hits = 0. Entry storage need not be cleared.
- **Reset mid-operation.** All queued entries are lost. Outputs reach their reset values immediately, without waiting for a clock edge.
- **Latency.** An entry enqueued at edge N is presented (`write_activate` = 1) during the cycle after edge N. With `write_done` tied high it retires at edge N+1.
- **Throughput.** With `write_done` tied high, one write retires per cycle, and continuous enqueue/retire holds count constant.
- **Stalled register file.** If `write_done` stays low, the head stays presented with stable `write_register` / `write_data` indefinitely.
- `count`, `empty` and `write_*` are functions of registered state only; no combinational path from `wb_valid`.

## Test plan

- **Reset then single write.** Release rst, enqueue (r1, 0xdead_beef) with `write_done` held 0 for 2 cycles, then 1.
  - Required: `write_activate` = 1 with r1 / 0xdead_beef for 3 cycles.
  - Required: `lookup_hit_1` = 1 for index 1 while queued; count returns to 0 after the `write_done` edge.
- **x0 discard.** Enqueue (r0, 0xffff_ffff).
  - Required: `wb_ready` handshake completes, count stays 0, `write_activate` stays 0, lookup of index 0 gives hit = 0.
- **Fill and wrap.** With `write_done` = 0, enqueue r1..r4 with data 0x11..0x44.
  - Required: count = 4, `wb_ready` = 0, a fifth request is held off.
  - Then `write_done` = 1: writes r1, r2, r3, r4 appear in order. Enqueue r5 = 0x55 after the first retire; it appears after r4, exercising pointer wrap.
- **Youngest-match forwarding.** Queue (r7, 0xaaaa_0001) then (r7, 0xbbbb_0002) with `write_done` = 0.
  - Required: `lookup_data_1` = 0xbbbb_0002 for index 7.
  - After the first retire, still 0xbbbb_0002; after the second retire, hit = 0.
- **Flush with concurrent traffic.** Three entries queued; assert `flush` together with `wb_valid` and `write_done`.
  - Required: next cycle count = 0, `write_activate` = 0, `write_data` = 0, and the flushed-cycle enqueue is not present.
- **Async reset mid-stream.** With count = 2, pull rst low between clock edges.
  - Required: `write_activate` = 0 and `empty` = 1 before the next rising edge.

Source files
------------

// File: rtl/register_writeback_queue.sv
// In-order writeback queue feeding the register-file write port.
// Entries retire on write_done; two lookup ports forward queued values.
module register_writeback_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [4:0]                 wb_register,
  input  logic [WIDTH-1:0]           wb_data,
  output logic [4:0]                 write_register,
  output logic [WIDTH-1:0]           write_data,
  output logic                       write_activate,
  input  logic                       write_done,
  input  logic [4:0]                 lookup_register_1,
  input  logic [4:0]                 lookup_register_2,
  output logic                       lookup_hit_1,
  output logic                       lookup_hit_2,
  output logic [WIDTH-1:0]           lookup_data_1,
  output logic [WIDTH-1:0]           lookup_data_2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [4:0]          reg_mem_q  [DEPTH];
  logic [4:0]          reg_mem_d  [DEPTH];
  logic [WIDTH-1:0]    data_mem_q [DEPTH];
  logic [WIDTH-1:0]    data_mem_d [DEPTH];

  logic enq;
  logic ret;

  assign wb_ready       = (count_q < CW'(DEPTH)) && !flush;
  assign write_activate = (state_q == PRESENT);
  assign write_register = write_activate ? reg_mem_q[head_q]  : '0;
  assign write_data     = write_activate ? data_mem_q[head_q] : '0;
  assign count          = count_q;
  assign empty          = (count_q == '0);

  // Handshake decode: register 0 requests complete the handshake but create no entry
  always_comb begin
    enq = wb_valid && wb_ready && (wb_register != 5'd0);
    ret = write_activate && write_done;
  end

  // Pointer, count and presentation-state next values; flush overrides all traffic
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (ret) head_d = head_q + PW'(1);
      if (enq) tail_d = tail_q + PW'(1);
      if (enq && !ret)      count_d = count_q + CW'(1);
      else if (!enq && ret) count_d = count_q - CW'(1);
    end
    state_d = (count_d != '0) ? PRESENT : IDLE;
  end

  // Entry storage next values; only the tail slot is written on enqueue
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      reg_mem_d[i]  = reg_mem_q[i];
      data_mem_d[i] = data_mem_q[i];
    end
    if (enq) begin
      reg_mem_d[tail_q]  = wb_register;
      data_mem_d[tail_q] = wb_data;
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while covered by count, so no reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      reg_mem_q[i]  <= reg_mem_d[i];
      data_mem_q[i] <= data_mem_d[i];
    end
  end

  // Forwarding lookup: walk oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    logic [PW-1:0] idx;
    lookup_hit_1  = 1'b0;
    lookup_hit_2  = 1'b0;
    lookup_data_1 = '0;
    lookup_data_2 = '0;
    idx           = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (lookup_register_1 != 5'd0 && reg_mem_q[idx] == lookup_register_1) begin
          lookup_hit_1  = 1'b1;
          lookup_data_1 = data_mem_q[idx];
        end
        if (lookup_register_2 != 5'd0 && reg_mem_q[idx] == lookup_register_2) begin
          lookup_hit_2  = 1'b1;
          lookup_data_2 = data_mem_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_writeback_queue.sv
// Bench for register_writeback_queue: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_register_writeback_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_register;
  logic [WIDTH-1:0]  wb_data;
  logic [4:0]        write_register;
  logic [WIDTH-1:0]  write_data;
  logic              write_activate;
  logic              write_done;
  logic [4:0]        lookup_register_1;
  logic [4:0]        lookup_register_2;
  logic              lookup_hit_1;
  logic              lookup_hit_2;
  logic [WIDTH-1:0]  lookup_data_1;
  logic [WIDTH-1:0]  lookup_data_2;
  logic [2:0]        count;
  logic              empty;

  register_writeback_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .wb_valid          (wb_valid),
    .wb_ready          (wb_ready),
    .wb_register       (wb_register),
    .wb_data           (wb_data),
    .write_register    (write_register),
    .write_data        (write_data),
    .write_activate    (write_activate),
    .write_done        (write_done),
    .lookup_register_1 (lookup_register_1),
    .lookup_register_2 (lookup_register_2),
    .lookup_hit_1      (lookup_hit_1),
    .lookup_hit_2      (lookup_hit_2),
    .lookup_data_1     (lookup_data_1),
    .lookup_data_2     (lookup_data_2),
    .count             (count),
    .empty             (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       r;
    logic [WIDTH-1:0] d;
  } entry_t;

  entry_t mq[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Youngest queued entry targeting idx; index 0 never matches
  task automatic look(input logic [4:0] idx, output logic hit, output logic [WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (idx != 5'd0) begin
      for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
        if (mq[i].r == idx) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
      end
    end
  endtask

  // One clock cycle: compare all outputs against the model, then advance the model at the edge
  task automatic tick();
    logic             e_ready, e_act, acc, rtr, h1, h2;
    logic [4:0]       e_reg;
    logic [WIDTH-1:0] e_data, d1, d2;
    #1;
    if (!rst) mq.delete();
    e_ready = (mq.size() < DEPTH) && !flush;
    e_act   = (mq.size() > 0);
    e_reg   = e_act ? mq[0].r : 5'd0;
    e_data  = e_act ? mq[0].d : '0;
    look(lookup_register_1, h1, d1);
    look(lookup_register_2, h2, d2);
    chk("wb_ready",       64'(wb_ready),       64'(e_ready));
    chk("write_activate", 64'(write_activate), 64'(e_act));
    chk("write_register", 64'(write_register), 64'(e_reg));
    chk("write_data",     64'(write_data),     64'(e_data));
    chk("count",          64'(count),          64'(mq.size()));
    chk("empty",          64'(empty),          64'(mq.size() == 0));
    chk("lookup_hit_1",   64'(lookup_hit_1),   64'(h1));
    chk("lookup_data_1",  64'(lookup_data_1),  64'(d1));
    chk("lookup_hit_2",   64'(lookup_hit_2),   64'(h2));
    chk("lookup_data_2",  64'(lookup_data_2),  64'(d2));
    acc = wb_valid && e_ready;
    rtr = e_act && write_done;
    @(posedge clk);
    if (rst) begin
      if (flush) mq.delete();
      else begin
        if (rtr) void'(mq.pop_front());
        if (acc && wb_register != 5'd0) mq.push_back('{wb_register, wb_data});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; wb_valid = 1'b0; wb_register = '0; wb_data = '0;
    write_done = 1'b0; lookup_register_1 = '0; lookup_register_2 = '0;
  endtask

  task automatic enq(input logic [4:0] r, input logic [WIDTH-1:0] d);
    wb_valid = 1'b1; wb_register = r; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    // Reset state literals
    chk("rst_wb_ready", 64'(wb_ready), 64'd1);
    chk("rst_activate", 64'(write_activate), 64'd0);
    chk("rst_wreg",     64'(write_register), 64'd0);
    chk("rst_wdata",    64'(write_data), 64'd0);
    chk("rst_empty",    64'(empty), 64'd1);
    chk("rst_count",    64'(count), 64'd0);
    chk("rst_hit1",     64'(lookup_hit_1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single write presented for three cycles, retire on write_done
    lookup_register_1 = 5'd1;
    enq(5'd1, 32'hdead_beef);
    for (int c = 0; c < 3; c++) begin
      write_done = (c == 2);
      #1;
      chk("single_act",  64'(write_activate), 64'd1);
      chk("single_reg",  64'(write_register), 64'd1);
      chk("single_data", 64'(write_data), 64'hdead_beef);
      chk("single_hit",  64'(lookup_hit_1), 64'd1);
      tick();
    end
    write_done = 1'b0;
    #1 chk("single_count_after", 64'(count), 64'd0);

    // r0 request accepted and discarded
    lookup_register_1 = 5'd0;
    wb_valid = 1'b1; wb_register = 5'd0; wb_data = 32'hffff_ffff;
    #1 chk("x0_ready", 64'(wb_ready), 64'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("x0_count", 64'(count), 64'd0);
    chk("x0_act",   64'(write_activate), 64'd0);
    chk("x0_hit",   64'(lookup_hit_1), 64'd0);

    // Fill to full, hold off a fifth, drain in order with a wrapped r5
    for (int i = 1; i <= 4; i++) enq(5'(i), 32'(i * 32'h11));
    wb_valid = 1'b1; wb_register = 5'd9; wb_data = 32'h99;
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(wb_ready), 64'd0);
    tick();
    wb_valid = 1'b0;
    write_done = 1'b1;
    #1 chk("drain_r1", 64'(write_register), 64'd1);
    tick();
    #1 chk("drain_r2", 64'(write_register), 64'd2);
    wb_valid = 1'b1; wb_register = 5'd5; wb_data = 32'h55;
    tick();
    wb_valid = 1'b0;
    #1 chk("drain_r3", 64'(write_register), 64'd3);
    tick();
    #1 chk("drain_r4", 64'(write_data), 64'h44);
    tick();
    #1 begin
      chk("drain_r5_reg",  64'(write_register), 64'd5);
      chk("drain_r5_data", 64'(write_data), 64'h55);
    end
    tick();
    write_done = 1'b0;
    #1 chk("drain_empty", 64'(empty), 64'd1);

    // Youngest-match forwarding
    lookup_register_1 = 5'd7;
    enq(5'd7, 32'haaaa_0001);
    enq(5'd7, 32'hbbbb_0002);
    #1 chk("fwd_young", 64'(lookup_data_1), 64'hbbbb_0002);
    write_done = 1'b1;
    tick();
    #1 chk("fwd_after1", 64'(lookup_data_1), 64'hbbbb_0002);
    tick();
    write_done = 1'b0;
    #1 chk("fwd_after2_hit", 64'(lookup_hit_1), 64'd0);

    // Flush with concurrent enqueue and retire
    enq(5'd1, 32'h1); enq(5'd2, 32'h2); enq(5'd3, 32'h3);
    flush = 1'b1; wb_valid = 1'b1; wb_register = 5'd6; wb_data = 32'h66; write_done = 1'b1;
    #1 chk("flush_ready", 64'(wb_ready), 64'd0);
    tick();
    idle_inputs();
    lookup_register_1 = 5'd6;
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_act",   64'(write_activate), 64'd0);
    chk("flush_data",  64'(write_data), 64'd0);
    chk("flush_hit6",  64'(lookup_hit_1), 64'd0);

    // Asynchronous reset mid-stream
    enq(5'd3, 32'h33); enq(5'd4, 32'h44);
    #1 chk("areset_pre_count", 64'(count), 64'd2);
    #1 rst = 1'b0;
    #1;
    chk("areset_act",   64'(write_activate), 64'd0);
    chk("areset_empty", 64'(empty), 64'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      wb_valid          = ($urandom_range(0, 3) != 0);
      wb_register       = 5'($urandom_range(0, 7));
      wb_data           = $urandom;
      write_done        = ($urandom_range(0, 2) == 0);
      flush             = ($urandom_range(0, 40) == 0);
      lookup_register_1 = 5'($urandom_range(0, 7));
      lookup_register_2 = 5'($urandom_range(0, 7));
      rst               = ($urandom_range(0, 300) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
